ring_rr_arbiter: RTL and testbench
==================================

// Module: ring_rr_arbiter
// PURPOSE
//  Round-robin, wormhole-locking arbiter for one ring router output port. Arbitrates among
//  local/left/right input requests and drives a registered one-hot grant vector directly
//  into the downstream output selector (grant[i] -> g0i). Holds the grant until the owner's
//  tail flit transfers, then rotates priority.
// PARAMETERS
//  NUM_PORTS       3   number of requesting inputs (grant[0]=local, [1]=left, [2]=right)
//  TIMEOUT_CYCLES  64  stall cycles before a forced release (only with LOCK_TIMEOUT_EN)
// PORTS
//  clk        in   1          rising-edge clock; only clock
//  rst        in   1          synchronous, active-low reset
//  req        in   NUM_PORTS  req[i]=1: input i has a valid flit for this output
//  tail       in   NUM_PORTS  tail[i]=1: input i's current flit is a tail (or single-flit pkt)
//  out_ready  in   1          downstream accepts a flit this cycle
//  grant      out  NUM_PORTS  one-hot or all-zero; registered
//  owner      out  2          index of granted port; 0 when idle
//  busy       out  1          1 while LOCKED
//  xfer       out  1          = busy & req[owner] & out_ready (combinational flit-transfer strobe)
//  timeout    out  1          one-cycle pulse on forced release
// BEHAVIOUR
//  - Reset (rst==0 at clk edge): state=IDLE, grant=0, owner=0, busy=0, timeout=0, rr_ptr=0,
//    stall counter=0. Reset mid-packet drops the lock unconditionally; no flit is transferred.
//  - States: IDLE, LOCKED.
//  - IDLE: if |req, pick first i with req[i]=1 scanning rr_ptr, rr_ptr+1, ... mod NUM_PORTS;
//    next cycle grant=onehot(i), owner=i, state=LOCKED. Latency req->grant = 1 cycle.
//    No req -> stay IDLE, grant=0.
//  - LOCKED: xfer asserted when req[owner] & out_ready. xfer with tail[owner]=1 -> next cycle
//    state=IDLE, grant=0, rr_ptr=(owner+1) mod NUM_PORTS. xfer with tail=0 -> stay LOCKED.
//  - req[owner] deasserted while LOCKED (wormhole bubble): lock held; other requests ignored.
//  - Requests from non-owners never affect grant while LOCKED.
//  - Tail release plus pending requests in the same cycle: one IDLE bubble cycle, then
//    arbitration with updated rr_ptr (max 2 cycles from tail xfer to next grant).
//  - Tail bits are ignored unless accompanying an xfer by the owner.
//  - rr_ptr modulo wrap: owner NUM_PORTS-1 -> rr_ptr 0.
//  - grant is never multi-hot; the selector's X default is never reached while busy.
// CONFIGURATION
//  LOCK_TIMEOUT_EN defined: stall counter resets to 0 on every xfer and on entry to LOCKED,
//    increments each LOCKED cycle without xfer; on reaching TIMEOUT_CYCLES-1 -> next cycle
//    release as for a tail (grant=0, rr_ptr advanced) and timeout=1 for exactly one cycle.
//    Counter width $clog2(TIMEOUT_CYCLES); saturation not needed (release clears it).
//  LOCK_TIMEOUT_EN undefined: no counter; lock held indefinitely; timeout tied 0.
//    Port list identical in both builds.
// STRUCTURE
//  - ring_arb_pkg: state enum {IDLE, LOCKED}; PORT_LOCAL=0, PORT_LEFT=1, PORT_RIGHT=2;
//    OWNER_W=2; function onehot(idx).
//  - Sub-module rr_pick: combinational rotate-priority picker (req, rr_ptr -> valid, idx).
//  - Top: state/grant/owner/rr_ptr registers, optional stall counter.
// TESTING
//  1. Reset: rst=0 for 2 cycles with req=3'b111 -> grant=0, busy=0, owner=0 throughout.
//  2. Rotation: req=3'b111 held, every flit tail, out_ready=1 -> grants 001,000,010,000,100,000,001.
//  3. Wormhole: port1 owns, 4-flit pkt, req[1] dropped 2 cycles mid-pkt, req=3'b101 asserted
//     -> grant stays 010 until tail xfer; then rr_ptr=2, next grant 100.
//  4. Backpressure: owner 0, out_ready=0 for 5 cycles -> xfer=0, grant=001 held; tail with
//     out_ready=1 -> grant=000 next cycle.
//  5. Mid-packet reset: owner 2, rst=0 one cycle -> grant=000, rr_ptr=0; then req=3'b110 -> grant=010.
//  6. LOCK_TIMEOUT_EN, TIMEOUT_CYCLES=8: owner 0 stalls (out_ready=0) -> release after 8 stall
//     cycles, timeout pulses once, next grant to port 1 if req[1]; without macro grant=001 held 100 cycles.

Source files
------------

// File: rtl/ring_arb_pkg.sv
// ring_arb_pkg: shared types and constants for the ring router output-port arbiter.
package ring_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int OWNER_W   = 2;
    localparam int MAX_PORTS = 4;   // largest port count an OWNER_W-bit index can address

    localparam logic [OWNER_W-1:0] PORT_LOCAL = 2'd0;
    localparam logic [OWNER_W-1:0] PORT_LEFT  = 2'd1;
    localparam logic [OWNER_W-1:0] PORT_RIGHT = 2'd2;

    // One-hot decode of a port index; callers narrow to their own port count.
    function automatic logic [MAX_PORTS-1:0] onehot(input logic [OWNER_W-1:0] idx);
        onehot = {{(MAX_PORTS-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/ring_rr_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority picker. Returns the first requesting
// port found scanning rr_ptr, rr_ptr+1, ... modulo NUM_PORTS.
module rr_pick
    import ring_arb_pkg::*;
#(
    parameter int NUM_PORTS = 3
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [OWNER_W-1:0]   rr_ptr,
    output logic                 valid,
    output logic [OWNER_W-1:0]   idx
);

    logic [OWNER_W-1:0] w_pos;

    // Scan from the farthest offset down so the closest requester to rr_ptr wins last.
    always_comb begin
        valid = 1'b0;
        idx   = {OWNER_W{1'b0}};
        w_pos = {OWNER_W{1'b0}};
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            w_pos = OWNER_W'((int'(rr_ptr) + k) % NUM_PORTS);
            if (req[w_pos]) begin
                valid = 1'b1;
                idx   = w_pos;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/ring_rr_arbiter.sv
// ring_rr_arbiter: round-robin, wormhole-locking arbiter for one ring router
// output port. A granted input keeps the port until its tail flit transfers,
// after which priority rotates to the next port.
// Optional feature macro: LOCK_TIMEOUT_EN -- when defined, a stalled lock is
// force-released after TIMEOUT_CYCLES cycles without a transfer and the
// timeout output pulses for one cycle. When undefined, timeout is tied low.
module ring_rr_arbiter
    import ring_arb_pkg::*;
#(
    parameter int NUM_PORTS      = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] tail,
    input  logic                 out_ready,
    output logic [NUM_PORTS-1:0] grant,
    output logic [OWNER_W-1:0]   owner,
    output logic                 busy,
    output logic                 xfer,
    output logic                 timeout
);

    arb_state_e           r_state;
    logic [NUM_PORTS-1:0] r_grant;
    logic [OWNER_W-1:0]   r_owner;
    logic [OWNER_W-1:0]   r_rr_ptr;
    logic                 r_timeout;

    arb_state_e           w_state_nxt;
    logic [NUM_PORTS-1:0] w_grant_nxt;
    logic [OWNER_W-1:0]   w_owner_nxt;
    logic [OWNER_W-1:0]   w_ptr_nxt;
    logic                 w_timeout_nxt;

    logic                 w_pick_valid;
    logic [OWNER_W-1:0]   w_pick_idx;
    logic                 w_busy;
    logic                 w_xfer;
    logic                 w_tail_rel;
    logic                 w_to_hit;
    logic                 w_release;
    logic [OWNER_W-1:0]   w_ptr_adv;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .valid  (w_pick_valid),
        .idx    (w_pick_idx)
    );

    assign w_busy     = (r_state == LOCKED);
    assign w_xfer     = w_busy & req[r_owner] & out_ready;
    assign w_tail_rel = w_xfer & tail[r_owner];
    assign w_release  = w_tail_rel | w_to_hit;
    assign w_ptr_adv  = (r_owner == OWNER_W'(NUM_PORTS - 1)) ? {OWNER_W{1'b0}}
                                                             : r_owner + OWNER_W'(1);

`ifdef LOCK_TIMEOUT_EN
    localparam int STALL_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [STALL_W-1:0] r_stall;

    // A lock that sits TIMEOUT_CYCLES cycles without a transfer is force-released.
    assign w_to_hit = w_busy & ~w_xfer & (r_stall == STALL_W'(TIMEOUT_CYCLES - 1));

    // Stall counter: cleared while idle, on every transfer and on release.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall <= {STALL_W{1'b0}};
        end else if (!w_busy || w_xfer || w_to_hit) begin
            r_stall <= {STALL_W{1'b0}};
        end else begin
            r_stall <= r_stall + STALL_W'(1);
        end
    end
`else
    assign w_to_hit = 1'b0;
`endif

    // Next-state and next-output logic for the IDLE/LOCKED arbiter.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_owner_nxt   = r_owner;
        w_ptr_nxt     = r_rr_ptr;
        w_timeout_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = LOCKED;
                    w_grant_nxt = NUM_PORTS'(onehot(w_pick_idx));
                    w_owner_nxt = w_pick_idx;
                end else begin
                    w_grant_nxt = {NUM_PORTS{1'b0}};
                    w_owner_nxt = PORT_LOCAL;
                end
            end
            LOCKED: begin
                // Non-owner requests and tails never reach here; only the owner matters.
                if (w_release) begin
                    w_state_nxt   = IDLE;
                    w_grant_nxt   = {NUM_PORTS{1'b0}};
                    w_owner_nxt   = PORT_LOCAL;
                    w_ptr_nxt     = w_ptr_adv;
                    w_timeout_nxt = w_to_hit;
                end else begin
                    w_state_nxt = LOCKED;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = {NUM_PORTS{1'b0}};
                w_owner_nxt = PORT_LOCAL;
            end
        endcase
    end

    // State, grant, owner, priority pointer and timeout pulse registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_grant   <= {NUM_PORTS{1'b0}};
            r_owner   <= PORT_LOCAL;
            r_rr_ptr  <= PORT_LOCAL;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_owner   <= w_owner_nxt;
            r_rr_ptr  <= w_ptr_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign grant   = r_grant;
    assign owner   = r_owner;
    assign busy    = w_busy;
    assign xfer    = w_xfer;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Self-checking bench for ring_rr_arbiter: a table of per-cycle vectors
// (inputs plus expected outputs) applied in a loop, with registered-output
// expectations queued on drive and popped after the clock edge, followed by
// a hand-written stall/timeout sequence. Honours LOCK_TIMEOUT_EN.
module tb_ring_rr_arbiter;

    typedef struct {
        logic       rst;
        logic [2:0] req;
        logic [2:0] tail;
        logic       ordy;
        logic       xfer;    // expected before the edge
        logic [2:0] grant;   // expected after the edge
        logic [1:0] owner;
        logic       busy;
        logic       to;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic [2:0] tail;
    logic       out_ready;
    logic [2:0] grant;
    logic [1:0] owner;
    logic       busy;
    logic       xfer;
    logic       timeout;

    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t vecs[$];
    vec_t sb[$];

    ring_rr_arbiter #(
        .NUM_PORTS      (3),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .tail      (tail),
        .out_ready (out_ready),
        .grant     (grant),
        .owner     (owner),
        .busy      (busy),
        .xfer      (xfer),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [2:0] rq, input logic [2:0] tl,
                                input logic rdy, input logic xf, input logic [2:0] g,
                                input logic [1:0] o, input logic b, input logic t);
        vec_t v;
        v.rst = r; v.req = rq; v.tail = tl; v.ordy = rdy; v.xfer = xf;
        v.grant = g; v.owner = o; v.busy = b; v.to = t;
        return v;
    endfunction

    task automatic check(input string name, input int step, input logic [2:0] act,
                         input logic [2:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s step %0d: got %b expected %b", name, step, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, check xfer before the edge, queue the rest.
    task automatic apply(input vec_t v, input int step);
        vec_t e;
        @(negedge clk);
        rst = v.rst; req = v.req; tail = v.tail; out_ready = v.ordy;
        #1;
        check("xfer", step, {2'b00, xfer}, {2'b00, v.xfer});
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard step %0d: got empty queue expected entry", step);
        end else begin
            e = sb.pop_front();
            check("grant",   step, grant,            e.grant);
            check("owner",   step, {1'b0, owner},    {1'b0, e.owner});
            check("busy",    step, {2'b00, busy},    {2'b00, e.busy});
            check("timeout", step, {2'b00, timeout}, {2'b00, e.to});
        end
    endtask

    initial begin
        rst = 1'b0; req = 3'b000; tail = 3'b000; out_ready = 1'b0;

        // 1. reset held with all requests
        vecs.push_back(mk(1'b0, 3'b111, 3'b000, 1'b1, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 3'b111, 3'b000, 1'b1, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0));
        // 2. rotation: every flit a tail
        vecs.push_back(mk(1'b1, 3'b111, 3'b111, 1'b1, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 3'b111, 3'b111, 1'b1, 1'b1, 3'b000, 2'd0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 3'b111, 3'b111, 1'b1, 1'b0, 3'b010, 2'd1, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 3'b111, 3'b111, 1'b1, 1'b1, 3'b000, 2'd0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 3'b111, 3'b111, 1'b1, 1'b0, 3'b100, 2'd2, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 3'b111, 3'b111, 1'b1, 1'b1, 3'b000, 2'd0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 3'b111, 3'b111, 1'b1, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0));
        // release port 0 (ptr -> 1), then port 1 wins
        vecs.push_back(mk(1'b1, 3'b001, 3'b001, 1'b1, 1'b1, 3'b000, 2'd0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 3'b010, 3'b000, 1'b1, 1'b0, 3'b010, 2'd1, 1'b1, 1'b0));
        // 3. wormhole: 4 flits, two-cycle bubble with others requesting
        vecs.push_back(mk(1'b1, 3'b010, 3'b000, 1'b1, 1'b1, 3'b010, 2'd1, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 3'b010, 3'b000, 1'b1, 1'b1, 3'b010, 2'd1, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 3'b101, 3'b101, 1'b1, 1'b0, 3'b010, 2'd1, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 3'b101, 3'b101, 1'b1, 1'b0, 3'b010, 2'd1, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 3'b111, 3'b101, 1'b1, 1'b1, 3'b010, 2'd1, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 3'b111, 3'b010, 1'b1, 1'b1, 3'b000, 2'd0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 3'b101, 3'b000, 1'b1, 1'b0, 3'b100, 2'd2, 1'b1, 1'b0));
        // 5. mid-packet reset with port 2 owning, then ptr must be back at 0
        vecs.push_back(mk(1'b0, 3'b110, 3'b000, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 3'b110, 3'b000, 1'b1, 1'b0, 3'b010, 2'd1, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 3'b010, 3'b010, 1'b1, 1'b1, 3'b000, 2'd0, 1'b0, 1'b0));
        // 4. backpressure: owner 0, five stalled cycles with tail and other requests
        vecs.push_back(mk(1'b1, 3'b001, 3'b000, 1'b0, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0));
        for (int i = 0; i < 5; i++) begin
            vecs.push_back(mk(1'b1, 3'b011, 3'b001, 1'b0, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0));
        end
        vecs.push_back(mk(1'b1, 3'b011, 3'b001, 1'b1, 1'b1, 3'b000, 2'd0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 3'b011, 3'b000, 1'b1, 1'b0, 3'b010, 2'd1, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 3'b010, 3'b010, 1'b1, 1'b1, 3'b000, 2'd0, 1'b0, 1'b0));
        // ptr now 2; port 0 takes the lock for the stall sequence
        vecs.push_back(mk(1'b1, 3'b011, 3'b000, 1'b0, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // 6. owner 0 stalls with port 1 waiting
`ifdef LOCK_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            apply(mk(1'b1, 3'b011, 3'b000, 1'b0, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0), 100 + i);
        end
        apply(mk(1'b1, 3'b011, 3'b000, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 1'b1), 107);
        apply(mk(1'b1, 3'b011, 3'b000, 1'b0, 1'b0, 3'b010, 2'd1, 1'b1, 1'b0), 108);
        apply(mk(1'b1, 3'b011, 3'b000, 1'b0, 1'b0, 3'b010, 2'd1, 1'b1, 1'b0), 109);
`else
        for (int i = 0; i < 100; i++) begin
            apply(mk(1'b1, 3'b011, 3'b000, 1'b0, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0), 100 + i);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
